stage_queue: RTL and testbench



---
 rtl/stage_queue.sv | 128 ++++++++++++
 tb/tb_stage_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/stage_queue.sv
// Multi-lane in-order decoupling queue between front-end stages: up to LANES
// entries enqueued and presented per cycle, ready/accept handshakes, one-cycle flush.
module stage_queue_checker #(
    parameter int LANES = 2
) (
    input logic             clk,
    input logic             reset,
    input logic [LANES-1:0] in_valid,
    input logic [LANES-1:0] out_valid,
    input logic [LANES-1:0] out_accept
);
    function automatic logic is_prefix(input logic [LANES-1:0] v);
        return ((v + LANES'(1)) & v) == {LANES{1'b0}};
    endfunction

    a_in_valid_prefix: assert property (@(posedge clk) disable iff (reset)
        is_prefix(in_valid));
    a_out_accept_prefix: assert property (@(posedge clk) disable iff (reset)
        is_prefix(out_accept));
    a_out_accept_subset: assert property (@(posedge clk) disable iff (reset)
        (out_accept & ~out_valid) == {LANES{1'b0}});
endmodule

module stage_queue #(
    parameter int WIDTH = 64,
    parameter int LANES = 2,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic [LANES-1:0]       out_accept,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - LANES);

    function automatic logic [CW-1:0] popcount(input logic [LANES-1:0] v);
        logic [CW-1:0] s;
        s = {CW{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            s = s + {{PW{1'b0}}, v[i]};
        end
        return s;
    endfunction

    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [CW-1:0]    n_in_s;
    logic [CW-1:0]    n_out_s;
    logic [PW-1:0]    wr_idx_s;

    // Handshake decode and next-state for pointers, occupancy and storage.
    always_comb begin
        n_in_s   = in_ready ? popcount(in_valid) : {CW{1'b0}};
        n_out_s  = popcount(out_accept & out_valid);
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        wr_idx_s = tail_q;
        mem_d    = mem_q;
        if (flush) begin
            head_d  = {PW{1'b0}};
            tail_d  = {PW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            // Each lane index wraps independently so a group may straddle DEPTH-1 -> 0.
            for (int i = 0; i < LANES; i++) begin
                wr_idx_s        = tail_q + PW'(i);
                mem_d[wr_idx_s] = (in_ready && in_valid[i]) ?
                                  in_data[i*WIDTH +: WIDTH] : mem_q[wr_idx_s];
            end
            head_d  = head_q + n_out_s[PW-1:0];
            tail_d  = tail_q + n_in_s[PW-1:0];
            count_d = count_q + n_in_s - n_out_s;
        end
    end

    // Read side and status flags, derived only from registered state.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            out_valid[i]                = (count_q > CW'(i));
            out_data[i*WIDTH +: WIDTH] = mem_q[head_q + PW'(i)];
        end
        in_ready = (count_q <= READY_MAX);
        empty    = (count_q == {CW{1'b0}});
        full     = (count_q == DEPTH_C);
        count    = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    stage_queue_checker #(.LANES(LANES)) u_checker (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .out_valid  (out_valid),
        .out_accept (out_accept)
    );
endmodule

// File: tb/tb_stage_queue.sv
// Directed bench for stage_queue: driver pushes expected entries into a scoreboard,
// a negedge monitor compares status and presented data against it.
module tb_stage_queue;
    localparam int WIDTH = 64;
    localparam int LANES = 2;
    localparam int DEPTH = 8;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic [LANES-1:0]       in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*WIDTH-1:0] out_data;
    logic [LANES-1:0]       out_accept;
    logic [3:0]             count;
    logic                   empty;
    logic                   full;

    int          n_checks;
    int          n_errors;
    int          cur_count;
    int          mdl_count;
    logic [63:0] exp_q [$];

    stage_queue #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_accept (out_accept),
        .count      (count),
        .empty      (empty),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the model tracks occupancy and the expected entry order.
    task automatic drive(input logic fl, input logic [1:0] iv, input logic [63:0] d0,
                         input logic [63:0] d1, input logic [1:0] acc);
        int n_out;
        @(posedge clk);
        #1;
        flush      = fl;
        in_valid   = iv;
        in_data    = {d1, d0};
        out_accept = acc;
        cur_count  = mdl_count;
        if (fl) begin
            exp_q.delete();
            mdl_count = 0;
        end else begin
            n_out = 0;
            for (int i = 0; i < LANES; i++) begin
                if (acc[i] && mdl_count > i) n_out++;
            end
            if (mdl_count <= DEPTH - LANES) begin
                if (iv[0]) begin exp_q.push_back(d0); mdl_count++; end
                if (iv[1]) begin exp_q.push_back(d1); mdl_count++; end
            end
            mdl_count = mdl_count - n_out;
        end
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b00);
    endtask

    // Monitor: status against the model, presented lanes against the scoreboard head.
    always @(negedge clk) begin
        int n_pop;
        chk("count", 64'(count), 64'(cur_count));
        chk("empty", 64'(empty), 64'(cur_count == 0));
        chk("full", 64'(full), 64'(cur_count == DEPTH));
        chk("in_ready", 64'(in_ready), 64'(cur_count <= DEPTH - LANES));
        chk("out_valid", 64'(out_valid), 64'({cur_count > 1, cur_count > 0}));
        if (!reset && !flush) begin
            n_pop = 0;
            for (int i = 0; i < LANES; i++) begin
                if (cur_count > i) begin
                    if (exp_q.size() > i) begin
                        chk("out_data", out_data[i*WIDTH +: WIDTH], exp_q[i]);
                    end else begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL out_data: lane %0d valid with empty scoreboard", i);
                    end
                    if (out_accept[i]) n_pop++;
                end
            end
            repeat (n_pop) void'(exp_q.pop_front());
        end
    end

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        cur_count  = 0;
        mdl_count  = 0;
        reset      = 1'b1;
        flush      = 1'b0;
        in_valid   = 2'b00;
        in_data    = '0;
        out_accept = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        repeat (5) idle();

        // Fill 2,4,6,8; fifth group refused while full.
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 2'b11, 64'hA0 + 64'(2*k), 64'hA1 + 64'(2*k), 2'b00);
        end
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b01);
        drive(1'b0, 2'b01, 64'hBAD0, 64'h0, 2'b00);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b01);
        idle();

        // Read group straddling index 7 -> 0.
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b01);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
        drive(1'b0, 2'b11, 64'hC0, 64'hC1, 2'b00);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b01);

        // Simultaneous enqueue and dequeue at count 4.
        drive(1'b0, 2'b11, 64'hD0, 64'hD1, 2'b00);
        drive(1'b0, 2'b11, 64'hD2, 64'hD3, 2'b00);
        drive(1'b0, 2'b11, 64'hD4, 64'hD5, 2'b01);
        idle();

        // Flush at count 6 with enqueue and accept active.
        drive(1'b0, 2'b01, 64'hE0, 64'h0, 2'b00);
        drive(1'b1, 2'b11, 64'hEE0, 64'hEE1, 2'b11);
        idle();
        drive(1'b0, 2'b11, 64'hF0, 64'hF1, 2'b00);
        idle();
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);

        // Write group straddling index 7 -> 0.
        drive(1'b0, 2'b01, 64'h100, 64'h0, 2'b00);
        drive(1'b0, 2'b11, 64'h101, 64'h102, 2'b01);
        drive(1'b0, 2'b11, 64'h103, 64'h104, 2'b11);
        drive(1'b0, 2'b11, 64'h105, 64'h106, 2'b01);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b01);

        // Asynchronous reset mid-stream at count 5.
        drive(1'b0, 2'b11, 64'h200, 64'h201, 2'b00);
        drive(1'b0, 2'b11, 64'h202, 64'h203, 2'b00);
        drive(1'b0, 2'b01, 64'h204, 64'h0, 2'b00);
        @(posedge clk);
        #3;
        reset      = 1'b1;
        in_valid   = 2'b00;
        out_accept = 2'b00;
        cur_count  = 0;
        mdl_count  = 0;
        exp_q.delete();
        #1;
        chk("rst_count", 64'(count), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
        chk("rst_full", 64'(full), 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        @(posedge clk);
        #1 reset = 1'b0;

        drive(1'b0, 2'b11, 64'h300, 64'h301, 2'b00);
        idle();
        drive(1'b0, 2'b00, 64'h0, 64'h0, 2'b11);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
